// File: rtl/tw_rom_pkg.sv
// Shared constants and width helpers for the twiddle-factor store.
package tw_rom_pkg;

    localparam logic [127:0] TW_ONE        = {64'd1, 64'd1};
    localparam logic [127:0] CONST_RST_DEF = 128'hfffffffeffffffc1_0200000000000000;

    localparam logic LD_HALF_LO = 1'b0;
    localparam logic LD_HALF_HI = 1'b1;

    // $clog2 collapses to 0 for a single-entry dimension; keep every index at least 1 bit
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int NUM_STAGE_DEF = 3;
    localparam int GROUPS_DEF    = 4;
    localparam int DEPTH_DEF     = 4;
    localparam int NG_W_DEF      = $clog2(GROUPS_DEF + 1);
    localparam int ST_W_DEF      = clog2_min1(NUM_STAGE_DEF);
    localparam int GI_W_DEF      = clog2_min1(GROUPS_DEF);
    localparam int DP_W_DEF      = clog2_min1(DEPTH_DEF);

endpackage

// File: rtl/tw_addr_gen.sv
// Read-sequence counters: depth, pass and group rotation for the active stage.
module tw_addr_gen
    import tw_rom_pkg::*;
#(
    parameter int SC_WIDTH = 3,
    parameter int S_WIDTH  = 4,
    parameter int ADV_A    = 4,
    parameter int ADV_B    = 6,
    parameter int PW       = 4,
    parameter int NG_W     = 3,
    parameter int GI_W     = 2,
    parameter int DP_W     = 2,
    parameter int DEPTH    = 4
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                CEN,
    input  logic [SC_WIDTH-1:0] stage_counter,
    input  logic [S_WIDTH-1:0]  state,
    input  logic [NG_W-1:0]     ngroups,
    input  logic [PW-1:0]       npass,
    output logic [DP_W-1:0]     dep,
    output logic [GI_W-1:0]     grp
);

    logic [SC_WIDTH-1:0] prev_stage;
    logic [PW-1:0]       pass;
    logic                stage_chg;
    logic                adv;
    logic                dep_last;
    logic                pass_last;
    logic                grp_last;

    assign stage_chg = (stage_counter != prev_stage);
    assign adv       = (state == S_WIDTH'(ADV_A)) || (state == S_WIDTH'(ADV_B));
    assign dep_last  = (dep == DP_W'(DEPTH - 1));
    assign pass_last = (pass >= npass - PW'(1));
    assign grp_last  = (NG_W'(grp) >= ngroups - NG_W'(1));

    // A stage change restarts the walk regardless of enable or controller state
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            prev_stage <= '0;
            dep        <= '0;
            pass       <= '0;
            grp        <= '0;
        end else begin
            prev_stage <= stage_counter;
            if (stage_chg) begin
                dep  <= '0;
                pass <= '0;
                grp  <= '0;
            end else if (!CEN) begin
                if (adv) begin
                    if (dep_last) begin
                        dep <= '0;
                        if (pass_last) begin
                            pass <= '0;
                            grp  <= grp_last ? '0 : grp + 1'b1;
                        end else begin
                            pass <= pass + 1'b1;
                        end
                    end else begin
                        dep <= dep + 1'b1;
                    end
                end else begin
                    dep <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/tw_rom_param.sv
// Run-time loadable twiddle store: flat register table plus per-stage constants.
module tw_rom_param
    import tw_rom_pkg::*;
#(
    parameter int DW        = 64,
    parameter int NUM_STAGE = 3,
    parameter int GROUPS    = 4,
    parameter int DEPTH     = 4,
    parameter int SC_WIDTH  = 3,
    parameter int S_WIDTH   = 4,
    parameter int ADV_A     = 4,
    parameter int ADV_B     = 6,
    parameter int PW        = 4,
    parameter logic [2*DW-1:0] CONST_RST = CONST_RST_DEF,
    localparam int P_WIDTH  = 2 * DW,
    localparam int NG_W     = $clog2(GROUPS + 1),
    localparam int ST_W     = clog2_min1(NUM_STAGE),
    localparam int GI_W     = clog2_min1(GROUPS)
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      CEN,
    input  logic [SC_WIDTH-1:0]       stage_counter,
    input  logic [S_WIDTH-1:0]        state,
    input  logic [NUM_STAGE*NG_W-1:0] cfg_ngroups,
    input  logic [NUM_STAGE*PW-1:0]   cfg_npass,
    input  logic                      ld_en,
    input  logic                      ld_half,
    input  logic                      ld_const,
    input  logic [ST_W-1:0]           ld_stage,
    input  logic [GI_W-1:0]           ld_group,
    input  logic [DW-1:0]             ld_data,
    output logic [P_WIDTH-1:0]        Q,
    output logic [P_WIDTH-1:0]        Q_const,
    output logic                      q_vld
);

    localparam int DP_W    = clog2_min1(DEPTH);
    localparam int ENTRIES = NUM_STAGE * GROUPS * DEPTH;
    localparam int AW      = clog2_min1(ENTRIES);
    localparam logic [P_WIDTH-1:0] ONE_PAIR = {{(DW-1){1'b0}}, 1'b1, {(DW-1){1'b0}}, 1'b1};

    logic [P_WIDTH-1:0] tbl [ENTRIES];
    logic [P_WIDTH-1:0] cst [NUM_STAGE];
    logic [DP_W-1:0]    ld_idx;
    logic [DP_W-1:0]    dep;
    logic [GI_W-1:0]    grp;
    logic [ST_W-1:0]    rd_stage;
    logic               stage_ok;
    logic               ld_stage_ok;
    logic               wr_tbl;
    logic               wr_cst;
    logic [AW-1:0]      wr_addr;
    logic [AW-1:0]      rd_addr;
    logic [NG_W-1:0]    ng_raw;
    logic [NG_W-1:0]    ng_eff;
    logic [PW-1:0]      np_raw;
    logic [PW-1:0]      np_eff;

    assign rd_stage    = stage_counter[ST_W-1:0];
    assign stage_ok    = int'(stage_counter) < NUM_STAGE;
    assign ld_stage_ok = int'(ld_stage) < NUM_STAGE;
    assign wr_tbl      = ld_en && ld_stage_ok && !ld_const && (int'(ld_group) < GROUPS);
    assign wr_cst      = ld_en && ld_stage_ok && ld_const;
    assign wr_addr     = AW'((int'(ld_stage) * GROUPS + int'(ld_group)) * DEPTH + int'(ld_idx));
    assign rd_addr     = AW'((int'(rd_stage) * GROUPS + int'(grp)) * DEPTH + int'(dep));

    // Zero counts behave as one; an out-of-range stage walks a single-entry geometry
    always_comb begin
        ng_raw = '0;
        np_raw = '0;
        ng_eff = NG_W'(1);
        np_eff = PW'(1);
        if (stage_ok) begin
            ng_raw = cfg_ngroups[int'(rd_stage)*NG_W +: NG_W];
            np_raw = cfg_npass[int'(rd_stage)*PW +: PW];
            if (ng_raw > NG_W'(GROUPS))
                ng_eff = NG_W'(GROUPS);
            else if (ng_raw != '0)
                ng_eff = ng_raw;
            if (np_raw != '0)
                np_eff = np_raw;
        end
    end

    tw_addr_gen #(
        .SC_WIDTH (SC_WIDTH),
        .S_WIDTH  (S_WIDTH),
        .ADV_A    (ADV_A),
        .ADV_B    (ADV_B),
        .PW       (PW),
        .NG_W     (NG_W),
        .GI_W     (GI_W),
        .DP_W     (DP_W),
        .DEPTH    (DEPTH)
    ) u_addr_gen (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .CEN           (CEN),
        .stage_counter (stage_counter),
        .state         (state),
        .ngroups       (ng_eff),
        .npass         (np_eff),
        .dep           (dep),
        .grp           (grp)
    );

    // Load index walks one group's depth per burst and restarts whenever the burst breaks
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            ld_idx <= '0;
        else if (!ld_en)
            ld_idx <= '0;
        else if (ld_stage_ok && !ld_const)
            ld_idx <= (ld_idx == DP_W'(DEPTH - 1)) ? '0 : ld_idx + 1'b1;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i] <= ONE_PAIR;
        end else if (wr_tbl) begin
            if (ld_half == LD_HALF_LO)
                tbl[wr_addr][DW-1:0] <= ld_data;
            else
                tbl[wr_addr][P_WIDTH-1:DW] <= ld_data;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++)
                cst[i] <= CONST_RST;
        end else if (wr_cst) begin
            if (ld_half == LD_HALF_LO)
                cst[ld_stage][DW-1:0] <= ld_data;
            else
                cst[ld_stage][P_WIDTH-1:DW] <= ld_data;
        end
    end

    // Same-edge write and read: the read sees the table before the write lands
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Q       <= ONE_PAIR;
            Q_const <= CONST_RST;
            q_vld   <= 1'b0;
        end else if (!CEN && stage_ok) begin
            Q       <= tbl[rd_addr];
            Q_const <= cst[rd_stage];
            q_vld   <= 1'b1;
        end else begin
            Q       <= ONE_PAIR;
            q_vld   <= 1'b0;
        end
    end

endmodule
